// File: rtl/mod4_pkg.sv
// Shared types and helpers for the mod-4 ones-count checker arbiter.
package mod4_pkg;

  localparam int MOD     = 4;
  localparam int CNT_W   = $clog2(MOD);
  localparam int MAX_REQ = 8;
  localparam int RR_W    = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  // First set request at or after ptr, wrapping. Callers zero-extend req to
  // MAX_REQ bits; the unused upper lanes are never set, so a mod-MAX_REQ search
  // returns the same index as a mod-N_REQ search.
  function automatic logic [RR_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                              input logic [RR_W-1:0]    ptr);
    logic [RR_W-1:0] pick;
    logic [RR_W-1:0] idx;
    pick = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      idx = ptr + RR_W'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mod4_counter.sv
// Two-bit wrapping ones counter; the shared datapath of the mod-4 checker.
module mod4_counter
  import mod4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(bit_in);
    end
  end

endmodule

// File: rtl/mod4_check_arbiter.sv
// Round-robin arbiter sharing one bit-serial mod-4 ones-count checker between
// N_REQ serial sources; holds the grant for a whole frame, then reports.
module mod4_check_arbiter
  import mod4_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] bit_vld,
  input  logic [N_REQ-1:0] bit_in,
  input  logic [N_REQ-1:0] last,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             done,
  output logic [ID_W-1:0]  done_id,
  output logic             is_mul4,
  output logic [1:0]       ones_mod,
  output logic             err
);

  state_t            state, state_d;
  logic [ID_W-1:0]   rr_ptr, g_idx, sel, g_next;
  logic [LEN_W-1:0]  len;
  logic [CNT_W-1:0]  cnt, cnt_inc;
  logic              acc, acc_bit, acc_last, req_g, at_max;
  logic              finish, abort, any_req;

  // Lane selection through the one-hot grant keeps non-granted lanes out.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc      = |(bit_vld & gnt);
    acc_bit  = |(bit_in & gnt);
    acc_last = |(last & gnt);
    req_g    = |(req & gnt);
    any_req  = |req;
    at_max   = (len == LEN_W'(MAX_LEN - 1));
    cnt_inc  = cnt + CNT_W'(acc_bit);
    finish   = (state == RUN) && acc && (acc_last || at_max);
    abort    = (state == RUN) && !finish && !req_g;
    sel      = ID_W'(rr_pick(MAX_REQ'(req), RR_W'(rr_ptr)));
    g_next   = (g_idx == ID_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
    state_d  = state;
    case (state)
      IDLE:    if (any_req) state_d = RUN;
      RUN: begin
        if (finish)     state_d = REPORT;
        else if (abort) state_d = IDLE;
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  mod4_counter u_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .en     ((state == RUN) && acc),
    .bit_in (acc_bit),
    .cnt    (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      g_idx    <= '0;
      len      <= '0;
      gnt      <= '0;
      done     <= 1'b0;
      done_id  <= '0;
      is_mul4  <= 1'b0;
      ones_mod <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_d;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          len <= '0;
          if (any_req) begin
            g_idx <= sel;
            gnt   <= N_REQ'(1) << sel;
          end
        end
        RUN: begin
          if (finish) begin
            // A last bit wins over the length limit, even on the final slot.
            gnt      <= '0;
            done     <= 1'b1;
            done_id  <= g_idx;
            ones_mod <= cnt_inc;
            is_mul4  <= acc_last && (cnt_inc == '0);
            err      <= !acc_last;
          end else if (abort) begin
            gnt    <= '0;
            rr_ptr <= g_next;
          end else if (acc) begin
            len <= len + 1'b1;
          end
        end
        REPORT:  rr_ptr <= g_next;
        default: gnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mod4_check_arbiter.sv
// Scoreboard bench for mod4_check_arbiter: directed frames push expected
// reports; a monitor pops and compares on every done pulse.
module tb_mod4_check_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, bit_vld, bit_in, last;
  logic [3:0] gnt;
  logic       busy, done, is_mul4, err;
  logic [1:0] done_id, ones_mod;

  typedef struct {
    int         id;
    logic [1:0] m;
    logic       mul4;
    logic       er;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mod4_check_arbiter #(
    .N_REQ(4), .ID_W(2), .MAX_LEN(64), .LEN_W(7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .bit_vld  (bit_vld),
    .bit_in   (bit_in),
    .last     (last),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .is_mul4  (is_mul4),
    .ones_mod (ones_mod),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_done_id"}, done_id, 0);
    check({tag, "_is_mul4"}, is_mul4, 0);
    check({tag, "_ones_mod"}, ones_mod, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  // One complete frame on one lane; optional stall gaps and noise on idle lanes.
  task automatic run_frame(input int lane, input logic [63:0] bits, input int n,
                           input bit with_last, input bit gaps, input bit noise,
                           input logic [1:0] e_mod, input bit e_mul4, input bit e_err);
    int         waitc;
    logic [3:0] oh;
    oh = 4'(1 << lane);
    req[lane] = 1'b1;
    waitc = 0;
    while (!gnt[lane] && waitc < 40) begin
      tick();
      waitc++;
    end
    check("grant_latency", waitc, 1);
    check("grant_onehot", gnt, oh);
    sb.push_back('{lane, e_mod, e_mul4, e_err});
    if (noise) begin
      bit_vld = ~oh;
      bit_in  = ~oh;
      last    = ~oh;
    end
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        bit_vld[lane] = 1'b0;
        bit_in[lane]  = 1'b1;
        last[lane]    = 1'b1;
        repeat ((i % 3) + 1) tick();
      end
      bit_vld[lane] = 1'b1;
      bit_in[lane]  = bits[i];
      last[lane]    = with_last && (i == n - 1);
      tick();
    end
    bit_vld = '0;
    bit_in  = '0;
    last    = '0;
    req[lane] = 1'b0;
    check("done_pulse", done, 1);
    check("gnt_cleared", gnt, 0);
    check("busy_report", busy, 1);
    drain();
    tick();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_id", done_id, e.id);
          check("ones_mod", ones_mod, e.m);
          check("is_mul4", is_mul4, e.mul4);
          check("err", err, e.er);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    req = '0; bit_vld = '0; bit_in = '0; last = '0;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_gnt", gnt, 0);
      check("idle_busy", busy, 0);
    end

    // bits 1,1,0,1,1 -> four ones; then 1,1,1 -> three ones
    run_frame(1, 64'h1B, 5, 1, 0, 1, 2'd0, 1, 0);
    run_frame(1, 64'h07, 3, 1, 0, 1, 2'd3, 0, 0);
    // nine ones with 1..3 cycle stalls
    run_frame(2, 64'h1FF, 9, 1, 1, 1, 2'd1, 0, 0);
    // 64 zeros with no last -> length overflow, then a normal frame (1,0,1)
    run_frame(3, 64'h0, 64, 0, 0, 0, 2'd0, 0, 1);
    run_frame(0, 64'h5, 3, 1, 0, 0, 2'd2, 0, 0);

    // Abort lane 2 after three bits; lanes 0 and 3 then contend from rr_ptr=3.
    req[2] = 1'b1;
    tick();
    check("abort_gnt", gnt, 4'b0100);
    bit_vld[2] = 1'b1; bit_in[2] = 1'b1;
    repeat (3) tick();
    bit_vld = '0; bit_in = '0;
    req = 4'b1001;
    tick();
    check("abort_gnt_clear", gnt, 0);
    check("abort_busy", busy, 0);
    tick();
    check("abort_next_gnt", gnt, 4'b1000);
    sb.push_back('{3, 2'd0, 1'b1, 1'b0});
    bit_vld[3] = 1'b1; bit_in[3] = 1'b0; last[3] = 1'b1;
    tick();
    bit_vld = '0; last = '0; req = '0;
    check("zero_done", done, 1);
    drain();
    tick();

    // bits 1,1,1,0,1,1 -> five ones; leaves done_id=2, ones_mod=1, rr_ptr=3
    run_frame(2, 64'h37, 6, 1, 0, 0, 2'd1, 0, 0);

    // Reset in the middle of a lane-1 frame.
    req[1] = 1'b1;
    tick();
    check("midrst_gnt", gnt, 4'b0010);
    bit_vld[1] = 1'b1; bit_in[1] = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;

    // Round robin from rr_ptr=0; each lane sends one bit with last.
    req = 4'b1111; bit_vld = 4'b1111; last = 4'b1111; bit_in = 4'b0101;
    tick();
    check("rr_first_gnt", gnt, 4'b0001);
    sb.push_back('{0, 2'd1, 1'b0, 1'b0});
    sb.push_back('{1, 2'd0, 1'b1, 1'b0});
    sb.push_back('{2, 2'd1, 1'b0, 1'b0});
    sb.push_back('{3, 2'd0, 1'b1, 1'b0});
    sb.push_back('{0, 2'd1, 1'b0, 1'b0});
    drain();
    req = '0; bit_vld = '0; last = '0; bit_in = '0;
    repeat (4) tick();
    check("rr_end_gnt", gnt, 0);
    check("rr_end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod4_check_arbiter.md
Name: mod4_check_arbiter

Overview:
- Shares one bit-serial "ones count is a multiple of 4" checker between N_REQ requesters.
- Each requester streams a frame of single bits, terminated by a last flag.
- Grants are round-robin. The block holds the grant for a whole frame, then reports the requester id and the mod-4 verdict.
- Sits between the serial sources and downstream status logic; it replaces per-source mod-4 FSMs.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- ID_W, 2: width of the requester index; must be ≥ clog2(N_REQ).
- MAX_LEN, 64: maximum accepted bits per frame; reaching it without last is an error.
- LEN_W, 7: width of the frame bit counter; must be ≥ clog2(MAX_LEN+1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N_REQ  per-requester frame request; held high until the frame ends.
- bit_vld  in  N_REQ  per-requester data-bit valid.
- bit_in  in  N_REQ  per-requester serial data bit.
- last  in  N_REQ  per-requester last-bit marker; meaningful only with bit_vld.
- gnt  out  N_REQ  one-hot grant, registered.
- busy  out  1  high in RUN and REPORT.
- done  out  1  one-cycle result pulse.
- done_id  out  ID_W  index of the requester whose frame finished.
- is_mul4  out  1  ones count ≡ 0 mod 4; valid with done.
- ones_mod  out  2  final ones count mod 4; valid with done.
- err  out  1  pulses with done when the frame hit MAX_LEN without last.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0, count=0, len=0.
  - All outputs are 0: gnt, busy, done, done_id, is_mul4, ones_mod, err.
  - Reset mid-frame abandons the frame with no done pulse.
- States: IDLE, RUN, REPORT.
- IDLE:
  - If any req is high, pick the first requester at or after rr_ptr, searching upward with wrap.
  - Next cycle: gnt=onehot(sel), state=RUN, count=0, len=0.
  - Grant latency: 1 cycle from req seen to gnt visible.
- RUN (granted index g):
  - A bit is accepted only when bit_vld[g]=1. bit_vld, bit_in and last of non-granted requesters are ignored.
  - On each accepted bit: count=(count+bit_in) mod 4 (2-bit wrap), len=len+1.
  - Accepted bit with last[g]=1 → REPORT.
    - ones_mod = count including this bit.
    - is_mul4 = (that value == 0).
    - err=0.
  - Accepted bit without last, where len+1 == MAX_LEN → REPORT.
    - ones_mod = count including this bit.
    - is_mul4=0, err=1.
  - req[g] drops before completion → IDLE. No done pulse; gnt cleared; rr_ptr = g+1 mod N_REQ.
    - If req[g] drops in the same cycle as an accepted last bit, the frame completes normally.
  - Cycles with bit_vld[g]=0 stall; there is no timeout.
- REPORT:
  - One cycle: done=1, done_id=g, gnt=0, busy=1.
  - rr_ptr = g+1 mod N_REQ, then → IDLE.
  - ones_mod, is_mul4, err and done_id hold their values until the next done. done is the qualifier.
- Throughput: next grant is visible no earlier than 2 cycles after done (REPORT → IDLE → RUN).
- Empty frame: impossible; a frame ends only on an accepted bit.
- Zero ones → ones_mod=0, is_mul4=1.
- gnt is always one-hot or zero; never more than one bit set.

Decomposition:
- Shared package mod4_pkg:
  - state enum {IDLE, RUN, REPORT}.
  - localparam MOD=4.
  - Function rr_pick(req, ptr) returning the index.
- One natural sub-module: mod4_counter (clk, rst, clr, en, bit_in → cnt[1:0]), the 2-bit wrapping ones counter.
- Arbiter and FSM stay in the top module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → all outputs 0; with req=0 for 10 cycles, gnt stays 0.
- Single frame: req[1]=1, bits 1,1,0,1,1 (last on the 5th bit) → gnt=4'b0010 one cycle after req; done pulse one cycle after the last bit with done_id=1, ones_mod=0, is_mul4=1.
  - Repeat with bits 1,1,1 → ones_mod=3, is_mul4=0.
- Round-robin: req=4'b1111 held, each frame one bit → done_id order 0,1,2,3,0.
  - Bits driven on non-granted lanes do not change ones_mod.
- Stall and wrap: granted lane sends 9 ones with bit_vld gaps of 1–3 cycles → ones_mod=1, is_mul4=0, err=0.
- Overflow: MAX_LEN=64, 64 zeros with no last → done with err=1, is_mul4=0, ones_mod=0. The next frame then works normally.
- Abort and reset: req[2] dropped after 3 bits → no done; next grant goes to requester 3 if requesting.
  - rst asserted mid-frame → outputs 0 next cycle, rr_ptr=0.
